// File: rtl/hw1_tt_scanner.sv
// hw1_tt_scanner
//   Walks a 4-input combinational function through all 16 input points.
//   It captures the full truth table and streams out every minterm index
//   whose function value equals a target value latched at start.
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   rst          asynchronous, active-high reset
//   start        scan request, sampled only while idle
//   want         target function value, latched when start is accepted
//   a, b, c, d   registered stimulus to the external function, {a,b,c,d} = idx
//   f            function value returned for the driven a..d
//   m_valid      a matching minterm index is presented on m_index
//   m_ready      consumer accepts m_index
//   m_index      matching minterm index
//   busy         high while evaluating or emitting
//   done         one-cycle pulse when a scan completes
//   truth_table  captured truth table, bit i = f at idx i. The name is not
//                "table" because that word is a reserved keyword.
//   count        number of matches in the current or last scan (0..16)
//   dbg_state    current FSM state: 0 idle, 1 eval, 2 emit, 3 done
//
// Handshake: the match stream uses valid/ready. While m_valid is high,
// m_index stays stable until the first rising edge that sees m_valid and
// m_ready both high, which is the transfer. The consumer may hold m_ready
// low for any number of cycles; no timeout applies. m_ready has no effect
// while m_valid is low.
module hw1_tt_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        want,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        f,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [3:0]  m_index,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic        want_q, want_n;
  logic [3:0]  m_index_n;
  logic [15:0] table_n;
  logic [4:0]  count_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 4'd0;
      want_q      <= 1'b0;
      m_index     <= 4'd0;
      truth_table <= 16'd0;
      count       <= 5'd0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      want_q      <= want_n;
      m_index     <= m_index_n;
      truth_table <= table_n;
      count       <= count_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    want_n    = want_q;
    m_index_n = m_index;
    table_n   = truth_table;
    count_n   = count;
    case (state)
      S_IDLE: begin
        if (start) begin
          idx_n   = 4'd0;
          table_n = 16'd0;
          count_n = 5'd0;
          want_n  = want;
          state_n = S_EVAL;
        end
      end
      S_EVAL: begin
        table_n[idx] = f;
        if (f == want_q) begin
          // idx is held so a..d stay on the matching point while it is emitted.
          m_index_n = idx;
          count_n   = count + 5'd1;
          state_n   = S_EMIT;
        end else if (idx == 4'd15) begin
          state_n = S_DONE;
        end else begin
          idx_n = idx + 4'd1;
        end
      end
      S_EMIT: begin
        if (m_ready) begin
          if (idx == 4'd15) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = S_EVAL;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // The stimulus is the idx register itself, so it is glitch-free and stable
  // for the whole evaluation cycle.
  assign {a, b, c, d} = idx;

  // Moore outputs decoded from the state register.
  assign m_valid   = (state == S_EMIT);
  assign busy      = (state == S_EVAL) || (state == S_EMIT);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_hw1_tt_scanner.sv
module tb_hw1_tt_scanner;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        want = 1'b0;
  logic        a, b, c, d;
  logic        f;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_index;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  // External function: a lookup into whatever truth table the test selects.
  logic [15:0] tt_cur = 16'd0;
  assign f = tt_cur[{a, b, c, d}];

  hw1_tt_scanner dut (
    .clk(clk), .rst(rst), .start(start), .want(want),
    .a(a), .b(b), .c(c), .d(d), .f(f),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index),
    .busy(busy), .done(done), .truth_table(truth_table), .count(count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented match against the head of the
  // expected queue and pops on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_match", {28'd0, m_index}, 32'hFFFF_FFFF);
        end else begin
          check("m_index", {28'd0, m_index}, {28'd0, exp_q[0]});
          check("abcd_at_match", {28'd0, a, b, c, d}, {28'd0, m_index});
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (done) done_seen++;
    end
  end

  // ---------------- reference model ----------------
  // F = (~A & ~D) | (A & ~B) | (B & ~C), A is the MSB of the index.
  function automatic logic [15:0] formula_tt();
    logic [15:0] t;
    logic [3:0]  v;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      t[i] = (~v[3] & ~v[0]) | (v[3] & ~v[2]) | (v[2] & ~v[1]);
    end
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_abcd"}, {28'd0, a, b, c, d}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_m_index"}, {28'd0, m_index}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_table"}, {16'd0, truth_table}, 32'd0);
    check({tag, "_count"}, {27'd0, count}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- driver ----------------
  // rdy_mode: 0 random ready, 1 ready tied high, 2 stall first match 5 cycles.
  // nscans > 1 holds start high so the block restarts on each idle entry.
  task automatic run_scan(input logic [15:0] tt, input logic w, input int rdy_mode,
                          input int nscans);
    int exp_cnt, busy_cyc, stalled, scans_left;
    bit timed_out;
    tt_cur  = tt;
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) if (tt[i] == w) exp_cnt++;
    for (int s = 0; s < nscans; s++)
      for (int i = 0; i < 16; i++)
        if (tt[i] == w) exp_q.push_back(4'(i));
    want    = w;
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    if (nscans == 1) begin
      start = 1'b0;
      want  = 1'($urandom_range(0, 1));
    end
    scans_left = nscans;
    busy_cyc   = 0;
    stalled    = 0;
    timed_out  = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (rdy_mode)
        0: m_ready = ($urandom_range(0, 3) != 0);
        1: m_ready = 1'b1;
        default: begin
          if (m_valid && stalled < 5) begin
            m_ready = 1'b0;
            stalled++;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("table", {16'd0, truth_table}, {16'd0, tt});
        check("count", {27'd0, count}, exp_cnt);
        if (rdy_mode == 1) check("busy_cycles", busy_cyc, 16 + exp_cnt);
        busy_cyc = 0;
        scans_left--;
        if (scans_left == 0) begin
          timed_out = 1'b0;
          start     = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    if (timed_out) begin
      check("scan_timeout", 32'd1, 32'd0);
      start = 1'b0;
      rst = 1'b1; #2; rst = 1'b0;
      exp_q.delete();
    end else begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {30'd0, dbg_state}, 32'd0);
      check("table_hold", {16'd0, truth_table}, {16'd0, tt});
      check("count_hold", {27'd0, count}, exp_cnt);
      check("queue_drained", exp_q.size(), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_before;
    bit found;
    #1 rst = 1'b1;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Formula, want=1 and want=0, ready tied high.
    run_scan(formula_tt(), 1'b1, 1, 1);
    check("formula_table_const", {16'd0, truth_table}, 32'h3F75);
    check("formula_count1", {27'd0, count}, 32'd11);
    run_scan(formula_tt(), 1'b0, 1, 1);
    check("formula_count0", {27'd0, count}, 32'd5);

    // Back-pressure on the first match.
    run_scan(formula_tt(), 1'b1, 2, 1);

    // Start held high: exactly one scan per idle entry, identical results.
    run_scan(formula_tt(), 1'b1, 1, 2);

    // All-match and no-match corners.
    run_scan(16'hFFFF, 1'b1, 1, 1);
    check("all_match_count", {27'd0, count}, 32'd16);
    run_scan(16'h0000, 1'b1, 1, 1);

    // Reset while emitting index 5.
    tt_cur = formula_tt();
    exp_q.push_back(4'd0); exp_q.push_back(4'd2);
    exp_q.push_back(4'd4); exp_q.push_back(4'd5);
    want = 1'b1; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (m_valid && m_index == 4'd5) begin
        m_ready = 1'b0;
        found = 1'b1;
        break;
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("reached_emit5", {31'd0, found}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    exp_q.delete();
    done_before = done_seen;
    @(negedge clk) rst = 1'b0;
    m_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", done_seen, done_before);
    run_scan(formula_tt(), 1'b1, 1, 1);

    // Random tables, targets and back-pressure.
    for (int n = 0; n < 8; n++)
      run_scan(16'($urandom), 1'($urandom_range(0, 1)), 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
